gshare_predictor: RTL and testbench

- Parametrised next-generation direction/target predictor for the fetch stage.
- Supports two index modes: bimodal (PC-indexed) and gshare (PC XOR global history).
- Contains a PHT of saturating counters with configurable width, a tagged direct-mapped BTB, a global history register and 32-bit accuracy statistics.
- Fetch presents decoded branch flags; MEM-stage resolution trains the tables. The predictor is non-speculative: the GHR advances only at resolution.

---
 rtl/gshare_predictor.sv | 137 +++++++++++++
 tb/tb_gshare_predictor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Branch direction/target predictor: PHT of saturating counters (bimodal or gshare
// index), tagged direct-mapped BTB, non-speculative global history, resolve statistics.
//
// state | meaning
// INIT  | sweeping PHT to weakly-not-taken, predictions and training suppressed
// RUN   | normal lookup and training
module gshare_predictor #(
   parameter int PHT_BITS = 10,
   parameter int CTR_BITS = 2,
   parameter int GHR_BITS = 10,
   parameter int BTB_BITS = 6,
   parameter int MODE     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   input  logic        fetch_is_branch,
   input  logic        resolve_valid,
   input  logic [31:0] resolve_pc,
   input  logic        resolve_is_cond,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_target,
   input  logic        resolve_predicted,
   output logic        ready,
   output logic        taken,
   output logic [31:0] taken_addr,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int PHT_N = 1 << PHT_BITS;
   localparam int BTB_N = 1 << BTB_BITS;
   localparam int TAG_W = 30 - BTB_BITS;
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

   typedef enum logic {INIT, RUN} state_t;

   state_t              state;
   logic [PHT_BITS-1:0] ptr;
   logic [GHR_BITS-1:0] ghr;

   logic [CTR_BITS-1:0] pht        [PHT_N];
   logic [BTB_N-1:0]    btb_valid;
   logic [TAG_W-1:0]    btb_tag    [BTB_N];
   logic [31:0]         btb_target [BTB_N];
   logic                btb_jump   [BTB_N];

   logic [PHT_BITS-1:0] ghr_ext, f_pidx, r_pidx;
   logic [BTB_BITS-1:0] f_bidx, r_bidx;
   logic [TAG_W-1:0]    f_tag, r_tag;
   logic                hit, predict, train, train_cond;
   logic [CTR_BITS-1:0] r_ctr, ctr_next;
   logic                unused_pc_bits;

   assign ghr_ext = (MODE == 1) ? PHT_BITS'(ghr) : '0;
   assign f_pidx  = fetch_pc[PHT_BITS+1:2] ^ ghr_ext;
   assign r_pidx  = resolve_pc[PHT_BITS+1:2] ^ ghr_ext;
   assign f_bidx  = fetch_pc[BTB_BITS+1:2];
   assign r_bidx  = resolve_pc[BTB_BITS+1:2];
   assign f_tag   = fetch_pc[31:BTB_BITS+2];
   assign r_tag   = resolve_pc[31:BTB_BITS+2];
   assign unused_pc_bits = ^{fetch_pc[1:0], resolve_pc[1:0]};

   // Lookup reads the tables before any same-cycle training lands.
   assign hit = fetch_valid & fetch_is_branch & btb_valid[f_bidx] & (btb_tag[f_bidx] == f_tag);
   assign predict    = hit & (btb_jump[f_bidx] | pht[f_pidx][CTR_BITS-1]);
   assign train      = resolve_valid & (state == RUN);
   assign train_cond = train & resolve_is_cond;
   assign r_ctr      = pht[r_pidx];

   always_comb begin
      ctr_next = r_ctr;
      if (resolve_taken && r_ctr != CTR_MAX)
         ctr_next = r_ctr + 1'b1;
      else if (!resolve_taken && r_ctr != '0)
         ctr_next = r_ctr - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (state == INIT)
         pht[ptr] <= CTR_WNT;
      else if (train_cond)
         pht[r_pidx] <= ctr_next;
   end

   always_ff @(posedge clk) begin
      if (train && resolve_taken) begin
         btb_tag[r_bidx]    <= r_tag;
         btb_target[r_bidx] <= resolve_target;
         btb_jump[r_bidx]   <= ~resolve_is_cond;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= INIT;
         ptr              <= '0;
         ghr              <= '0;
         ready            <= 1'b0;
         taken            <= 1'b0;
         taken_addr       <= '0;
         branch_count     <= '0;
         mispredict_count <= '0;
         btb_valid        <= '0;
      end else if (state == INIT) begin
         ptr        <= ptr + 1'b1;
         taken      <= 1'b0;
         taken_addr <= '0;
         if (ptr == '1) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end else begin
         if (flush || !predict) begin
            taken      <= 1'b0;
            taken_addr <= '0;
         end else begin
            taken      <= 1'b1;
            taken_addr <= btb_target[f_bidx];
         end
         if (train) begin
            if (branch_count != '1)
               branch_count <= branch_count + 32'd1;
            if (resolve_predicted != resolve_taken && mispredict_count != '1)
               mispredict_count <= mispredict_count + 32'd1;
            if (train_cond)
               ghr <= GHR_BITS'({ghr, resolve_taken});
            if (resolve_taken)
               btb_valid[r_bidx] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a bimodal and a gshare (4-bit history) instance share
// stimulus and are checked every cycle against an array-based model of the predictor.
module tb_gshare_predictor;

   localparam int NP  = 1024;
   localparam int NB  = 64;
   localparam int WNT = 1;

   logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
   logic        fv = 1'b0, fb = 1'b0, rv = 1'b0, rc = 1'b0, rt = 1'b0, rp = 1'b0;
   logic [31:0] fpc = '0, rpc = '0, rtg = '0;

   logic        rdy [2];
   logic        tk  [2];
   logic [31:0] ta  [2];
   logic [31:0] bcnt[2];
   logic [31:0] mcnt[2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gshare_predictor #(.MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fetch_valid(fv), .fetch_pc(fpc), .fetch_is_branch(fb),
      .resolve_valid(rv), .resolve_pc(rpc), .resolve_is_cond(rc), .resolve_taken(rt),
      .resolve_target(rtg), .resolve_predicted(rp),
      .ready(rdy[0]), .taken(tk[0]), .taken_addr(ta[0]),
      .branch_count(bcnt[0]), .mispredict_count(mcnt[0]));

   gshare_predictor #(.GHR_BITS(4), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fetch_valid(fv), .fetch_pc(fpc), .fetch_is_branch(fb),
      .resolve_valid(rv), .resolve_pc(rpc), .resolve_is_cond(rc), .resolve_taken(rt),
      .resolve_target(rtg), .resolve_predicted(rp),
      .ready(rdy[1]), .taken(tk[1]), .taken_addr(ta[1]),
      .branch_count(bcnt[1]), .mispredict_count(mcnt[1]));

   // ---------------- reference model ----------------
   bit          model_on = 0;
   int          since;
   logic        e_ready;
   logic        e_taken[2];
   logic [31:0] e_addr [2];
   logic [31:0] e_bc, e_mc;
   int          pht  [2][NP];
   int          ghr  [2];
   bit          bv   [2][NB];
   logic [31:0] btag [2][NB];
   logic [31:0] btgt [2][NB];
   bit          bj   [2][NB];
   int          mb, mi;
   bit          mhit, mpred;

   function automatic int pidx(int m, logic [31:0] pc);
      int i = int'((pc >> 2) & 32'(NP - 1));
      if (m == 1) i = i ^ ghr[1];
      return i;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_on = 1;
         since    = 0;
         e_ready  = 0;
         e_bc     = '0;
         e_mc     = '0;
         for (int m = 0; m < 2; m++) begin
            e_taken[m] = 0;
            e_addr[m]  = '0;
            ghr[m]     = 0;
            for (int i = 0; i < NP; i++) pht[m][i] = WNT;
            for (int b = 0; b < NB; b++) bv[m][b] = 0;
         end
      end else if (since < NP) begin
         since++;
         e_ready = (since == NP);
         for (int m = 0; m < 2; m++) begin
            e_taken[m] = 0;
            e_addr[m]  = '0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            mb    = int'((fpc >> 2) % NB);
            mhit  = fv && fb && bv[m][mb] && (btag[m][mb] == (fpc >> 8));
            mpred = mhit && (bj[m][mb] || pht[m][pidx(m, fpc)] >= 2);
            e_taken[m] = mpred && !flush;
            e_addr[m]  = e_taken[m] ? btgt[m][mb] : 32'd0;
            if (rv) begin
               if (rc) begin
                  mi = pidx(m, rpc);
                  if (rt) pht[m][mi] = (pht[m][mi] == 3) ? 3 : pht[m][mi] + 1;
                  else    pht[m][mi] = (pht[m][mi] == 0) ? 0 : pht[m][mi] - 1;
                  ghr[m] = ((ghr[m] << 1) | int'(rt)) & 15;
               end
               if (rt) begin
                  mb = int'((rpc >> 2) % NB);
                  bv[m][mb]   = 1;
                  btag[m][mb] = rpc >> 8;
                  btgt[m][mb] = rtg;
                  bj[m][mb]   = !rc;
               end
            end
         end
         if (rv) begin
            if (e_bc != 32'hFFFF_FFFF) e_bc = e_bc + 1;
            if (rp != rt && e_mc != 32'hFFFF_FFFF) e_mc = e_mc + 1;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         for (int m = 0; m < 2; m++) begin
            chk($sformatf("ready[%0d]", m), 32'(rdy[m]), 32'(e_ready));
            chk($sformatf("taken[%0d]", m), 32'(tk[m]), 32'(e_taken[m]));
            chk($sformatf("taken_addr[%0d]", m), ta[m], e_addr[m]);
            chk($sformatf("branch_count[%0d]", m), bcnt[m], e_bc);
            chk($sformatf("mispredict_count[%0d]", m), mcnt[m], e_mc);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fv = 0; fb = 0; rv = 0; flush = 0;
   endtask

   task automatic fetch(logic [31:0] pc, logic br);
      fv = 1; fb = br; fpc = pc;
   endtask

   task automatic resolve(logic [31:0] pc, logic cond, logic tkn, logic [31:0] tgt, logic pred);
      rv = 1; rpc = pc; rc = cond; rt = tkn; rtg = tgt; rp = pred;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      cyc(2);
      rst_n = 1;
   endtask

   function automatic logic [31:0] rand_pc();
      return 32'h0040_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   initial begin
      #2 rst_n = 0;
      cyc(2);
      rst_n = 1;

      // INIT length, and a resolve during INIT is dropped
      resolve(32'h0040_0100, 1, 1, 32'h0040_0200, 0);
      cyc(1);
      idle();
      cyc(1022);
      chk("ready_low_1023", 32'(rdy[0]), 32'd0);
      chk("ready_low_1023_g", 32'(rdy[1]), 32'd0);
      cyc(1);
      chk("ready_high_1024", 32'(rdy[0]), 32'd1);
      chk("bcount_init_drop", bcnt[0], 32'd0);

      // bimodal: two taken resolves then a hit
      resolve(32'h0040_0100, 1, 1, 32'h0040_0200, 0);
      cyc(2);
      idle();
      fetch(32'h0040_0100, 1);
      cyc(1);
      chk("bimodal_taken", 32'(tk[0]), 32'd1);
      chk("bimodal_addr", ta[0], 32'h0040_0200);
      fetch(32'h0040_0100, 0);
      cyc(1);
      chk("not_branch_taken", 32'(tk[0]), 32'd0);
      chk("not_branch_addr", ta[0], 32'd0);

      // counter saturation: 3 stays 3, two not-taken reach 1
      idle();
      resolve(32'h0040_0100, 1, 1, 32'h0040_0200, 1);
      cyc(5);
      resolve(32'h0040_0100, 1, 0, 32'h0040_0200, 1);
      cyc(2);
      idle();
      fetch(32'h0040_0100, 1);
      cyc(1);
      chk("sat_then_nt", 32'(tk[0]), 32'd0);

      // fresh tables for the history tests
      do_reset();
      cyc(NP);
      resolve(32'h0000_1000, 1, 1, 32'h0000_1100, 0); cyc(1);
      resolve(32'h0000_1000, 1, 0, 32'h0000_1100, 0); cyc(1);
      resolve(32'h0000_1000, 1, 1, 32'h0000_1100, 0); cyc(1);
      resolve(32'h0000_1000, 1, 0, 32'h0000_1100, 0); cyc(1);
      idle();
      fetch(32'h0000_1000, 1);
      cyc(1);
      chk("gshare_hist_idx", 32'(tk[1]), 32'd0);
      chk("bimodal_tnt", 32'(tk[0]), 32'd0);

      // unconditional jump
      idle();
      resolve(32'h0000_2000, 0, 1, 32'h0000_3000, 0);
      cyc(1);
      idle();
      fetch(32'h0000_2000, 1);
      cyc(1);
      chk("jump_taken_b", 32'(tk[0]), 32'd1);
      chk("jump_taken_g", 32'(tk[1]), 32'd1);
      chk("jump_addr_g", ta[1], 32'h0000_3000);

      // same-cycle fetch and training: read-before-write
      idle();
      fetch(32'h0000_0500, 1);
      resolve(32'h0000_0500, 1, 1, 32'h0000_0600, 0);
      cyc(1);
      chk("rbw_first", 32'(tk[0]), 32'd0);
      idle();
      fetch(32'h0000_0500, 1);
      cyc(1);
      chk("rbw_next", 32'(tk[0]), 32'd1);
      chk("rbw_next_addr", ta[0], 32'h0000_0600);

      // flush on a hit still trains and counts
      fetch(32'h0000_0500, 1);
      flush = 1;
      resolve(32'h0000_0500, 1, 1, 32'h0000_0600, 0);
      cyc(1);
      chk("flush_taken", 32'(tk[0]), 32'd0);
      chk("flush_addr", ta[0], 32'd0);
      chk("flush_bcount", bcnt[0], 32'd7);
      chk("flush_mcount", mcnt[0], 32'd5);
      chk("flush_bcount_g", bcnt[1], 32'd7);
      chk("flush_mcount_g", mcnt[1], 32'd5);

      // randomized traffic with aliasing PCs, including resets mid-RUN and mid-INIT
      idle();
      for (int i = 0; i < 4000; i++) begin
         if (i == 1500 || i == 1800) begin
            rst_n = 0;
            cyc(1);
            rst_n = 1;
         end
         flush = ($urandom_range(0, 15) == 0);
         fv    = ($urandom_range(0, 3) != 0);
         fb    = ($urandom_range(0, 3) != 0);
         fpc   = rand_pc();
         rv    = ($urandom_range(0, 1) == 1);
         rpc   = rand_pc();
         rc    = ($urandom_range(0, 4) != 0);
         rt    = ($urandom_range(0, 1) == 1);
         rtg   = $urandom & 32'hFFFF_FFFC;
         rp    = ($urandom_range(0, 1) == 1);
         cyc(1);
      end
      idle();
      cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
